// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the CPU datapath and a handshaked data memory.
// Stalls the CPU until the access completes, misaligns or times out.
module load_store_unit #(
  parameter int unsigned n       = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  input  logic         req_we,
  input  logic [2:0]   req_funct3,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  output logic         stall,
  output logic         rsp_valid,
  output logic [n-1:0] rsp_rdata,
  output logic         misalign,
  output logic         bus_err,
  output logic         mem_req,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [3:0]   mem_be,
  output logic [n-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [n-1:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      off_q;
  logic [2:0]      funct3_q;
  logic            we_q;

  logic [1:0]      req_off;
  logic            req_mis;
  logic [3:0]      req_be;
  logic [n-1:0]    req_lane_wdata;
  logic [n-1:0]    shifted;
  logic [n-1:0]    load_data;

  assign req_off = req_addr[1:0];

  // Request decode: alignment check plus store lane steering.
  always_comb begin
    req_mis        = 1'b0;
    req_be         = 4'b1111;
    req_lane_wdata = req_wdata;
    case (req_funct3)
      3'b000, 3'b100: req_mis = 1'b0;
      3'b001, 3'b101: req_mis = req_off[0];
      default:        req_mis = (req_off != 2'b00);
    endcase
    case (req_funct3[1:0])
      2'b00: begin
        req_be         = 4'b0001 << req_off;
        req_lane_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be         = 4'b0011 << {req_off[1], 1'b0};
        req_lane_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be         = 4'b1111;
        req_lane_wdata = req_wdata;
      end
    endcase
  end

  // Load extraction uses the captured offset and funct3.
  always_comb begin
    shifted   = mem_rdata >> {off_q, 3'b000};
    load_data = shifted;
    case (funct3_q)
      3'b000:  load_data = {{(n-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{(n-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {{(n-8){1'b0}}, shifted[7:0]};
      3'b101:  load_data = {{(n-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign stall = ((state_q == StIdle) && req_valid) || (state_q == StBusy);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      off_q     <= '0;
      funct3_q  <= '0;
      we_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            off_q    <= req_off;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            if (req_mis) begin
              state_q   <= StDone;
              rsp_valid <= 1'b1;
              misalign  <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state_q   <= StBusy;
              cnt_q     <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[n-1:2], 2'b00};
              mem_be    <= req_we ? req_be : 4'b1111;
              mem_wdata <= req_we ? req_lane_wdata : '0;
            end
          end
        end
        StBusy: begin
          if (mem_ack || (cnt_q == CntW'(TIMEOUT - 1))) begin
            state_q   <= StDone;
            rsp_valid <= 1'b1;
            bus_err   <= !mem_ack;
            rsp_rdata <= (mem_ack && !we_q) ? load_data : '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          rsp_valid <= 1'b0;
          misalign  <= 1'b0;
          bus_err   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: CPU driver, memory responder and response monitor.
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall, rsp_valid, misalign, bus_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        mem_ack_r = 1'b0;
  logic        stale_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  assign mem_ack = mem_ack_r | stale_ack;

  always #5 clock = ~clock;

  load_store_unit #(.n(32), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .misalign(misalign),
    .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          d;
    int          busy;
    logic [31:0] rdata;
  } mem_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        berr;
  } rsp_t;

  mem_t mem_q[$];
  rsp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: access size from funct3, lanes from byte offset, arithmetic replication.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                output logic mis, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] res);
    int unsigned o, size;
    logic [31:0] s;
    o = addr % 4;
    if (f3 == 3'd0 || f3 == 3'd4) size = 1;
    else if (f3 == 3'd1 || f3 == 3'd5) size = 2;
    else size = 4;
    mis = (addr % size) != 0;
    be  = 4'hF;
    wd  = 32'h0;
    if (we) begin
      if (f3 % 4 == 0) begin
        be = 4'(1 << o);
        wd = (wdata & 32'hFF) * 32'h01010101;
      end else if (f3 % 4 == 1) begin
        be = 4'(3 << (o & 2));
        wd = (wdata & 32'hFFFF) * 32'h00010001;
      end else begin
        wd = wdata;
      end
    end
    s = rdata >> (8 * o);
    case (f3)
      3'd0: begin res = s & 32'hFF; if (res >= 32'h80) res = res | 32'hFFFFFF00; end
      3'd1: begin res = s & 32'hFFFF; if (res >= 32'h8000) res = res | 32'hFFFF0000; end
      3'd4: res = s & 32'hFF;
      3'd5: res = s & 32'hFFFF;
      default: res = s;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the response cycle.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int d);
    logic mis;
    logic [3:0] be;
    logic [31:0] wd, res;
    mem_t m;
    rsp_t r;
    int busy, stall_cnt;
    bit got;
    model(we, f3, addr, wdata, rdata, mis, be, wd, res);
    busy = mis ? 0 : ((d + 1 < int'(TO)) ? d + 1 : int'(TO));
    if (!mis) begin
      m.we = we; m.addr = addr & 32'hFFFFFFFC; m.be = be; m.wd = wd;
      m.d = d; m.busy = busy; m.rdata = rdata;
      mem_q.push_back(m);
    end
    r.mis   = mis;
    r.berr  = !mis && (d >= int'(TO));
    r.rdata = (mis || r.berr || we) ? 32'h0 : res;
    exp_q.push_back(r);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    stall_cnt = 0;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (stall) stall_cnt++;
      if (rsp_valid) begin got = 1; break; end
    end
    if (!got) check("rsp_wait_expired", 32'd0, 32'd1);
    check("stall_cycles", stall_cnt, 1 + busy);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {26'b0, stall, rsp_valid, misalign, bus_err, mem_req, mem_we}, 32'h0);
    check({tag, "_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_addr"}, mem_addr, 32'h0);
    check({tag, "_be"}, {28'b0, mem_be}, 32'h0);
    check({tag, "_wdata"}, mem_wdata, 32'h0);
  endtask

  // Memory responder: checks the bus against the expected transaction and acks after d cycles.
  mem_t cur;
  logic active = 1'b0;
  int   mcnt = 0;
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      active = 1'b0;
      mem_ack_r = 1'b0;
    end else if (mem_req) begin
      if (!active) begin
        if (mem_q.size() == 0) begin
          check("unexpected_mem_req", 32'd1, 32'd0);
          cur = '{we: mem_we, addr: mem_addr, be: mem_be, wd: mem_wdata, d: 0, busy: 1,
                  rdata: 32'h0};
        end else begin
          cur = mem_q.pop_front();
        end
        active = 1'b1;
        mcnt = 0;
      end
      check("mem_we", {31'b0, mem_we}, {31'b0, cur.we});
      check("mem_addr", mem_addr, cur.addr);
      check("mem_be", {28'b0, mem_be}, {28'b0, cur.be});
      check("mem_wdata", mem_wdata, cur.wd);
      mcnt++;
      if (mcnt == cur.d + 1) begin
        mem_ack_r = 1'b1;
        mem_rdata = cur.rdata;
      end else begin
        mem_ack_r = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      if (active) begin
        check("mem_req_cycles", mcnt, cur.busy);
        active = 1'b0;
      end
      mem_ack_r = 1'b0;
      mem_rdata = $urandom;
    end
  end

  // Response monitor.
  rsp_t e;
  initial forever begin
    @(negedge clock);
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_misalign", {31'b0, misalign}, {31'b0, e.mis});
        check("rsp_bus_err", {31'b0, bus_err}, {31'b0, e.berr});
        check("done_stall", {31'b0, stall}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clock); #1;

    access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 1);
    access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FFFFFF, 0);
    access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FFFFFF, 0);
    access(1'b0, 3'd1, 32'h102, 32'h0, 32'h80FFFFFF, 0);
    access(1'b0, 3'd5, 32'h102, 32'h0, 32'h80FFFFFF, 0);
    access(1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 0);
    access(1'b1, 3'd0, 32'h101, 32'h00000055, 32'h0, 0);
    access(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0);
    access(1'b1, 3'd1, 32'h101, 32'h0, 32'h0, 0);
    access(1'b0, 3'd2, 32'h200, 32'h0, 32'h0, 1000);

    // Reset during the second BUSY cycle, then a stale ack after release.
    mem_q.push_back('{we: 1'b0, addr: 32'h200, be: 4'hF, wd: 32'h0, d: 1000, busy: 0,
                      rdata: 32'h0});
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h200;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    req_valid = 1'b0;
    @(posedge clock); #1;
    check_all_zero("midreset");
    reset = 1'b1;
    stale_ack = 1'b1;
    @(posedge clock); #1;
    stale_ack = 1'b0;
    check("stale_ack_req", {31'b0, mem_req}, 32'h0);
    check("stale_ack_rsp", {31'b0, rsp_valid}, 32'h0);
    access(1'b0, 3'd2, 32'h300, 32'h0, 32'h12345678, 0);

    for (int i = 0; i < 60; i++) begin
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom, int'($urandom_range(0, 5)));
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end

    repeat (3) @(posedge clock);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("mem_q_drained", mem_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle load/store unit placed between the single-cycle CPU datapath and a handshaked data memory. It replaces the CPU's direct RAM access.
- Takes a load or store request from the CPU and holds the CPU with a stall signal until the access completes.
- Generates byte enables and lane-replicated write data for sb/sh/sw, and extracts and extends load data for lb/lh/lw/lbu/lhu.
- Detects misaligned accesses and bus timeouts.

Parameters:
- n, 32, data/address width (byte lanes fixed at 4; n must be 32).
- TIMEOUT, 16, number of BUSY cycles without mem_ack before bus error (>=2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  CPU presents a load/store this cycle (ramR|ramW).
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  instr[14:12] of the memory instruction.
- req_addr  in  n  byte address from ALU.
- req_wdata  in  n  store source (rs2).
- stall  out  1  CPU must hold PC and suppress regfile write.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  n  extended load result (0 for stores/faults).
- misalign  out  1  with rsp_valid: access was misaligned, no memory access made.
- bus_err  out  1  with rsp_valid: memory timed out.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  write strobe.
- mem_addr  out  n  word-aligned address {addr[n-1:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  n  lane-replicated write data.
- mem_ack  in  1  memory accepted/completed; mem_rdata valid same cycle.
- mem_rdata  in  n  read word.

Behaviour:
- Reset (reset==0 at clock edge):
  - state=IDLE, timeout counter=0.
  - All outputs 0, including rsp_rdata.
  - Reset mid-BUSY abandons the access; mem_req deasserts the next cycle. A stale mem_ack after reset is ignored.
- States are IDLE, BUSY and DONE.
- IDLE:
  - stall = req_valid (combinational), so the CPU holds in the accept cycle.
  - On req_valid, capture addr, we, funct3 and wdata.
  - If misaligned, go to DONE with misalign flag; otherwise go to BUSY with counter=0.
- BUSY:
  - mem_req=1, stall=1. mem_we, mem_addr, mem_be and mem_wdata are stable from the captured values.
  - mem_ack is sampled only in BUSY. On mem_ack: register the extracted load data, then go to DONE.
  - If counter==TIMEOUT-1 and there is no ack: go to DONE with bus_err, rdata=0.
  - Otherwise counter increments.
- DONE:
  - rsp_valid=1, stall=0. misalign and bus_err are valid this cycle only.
  - The CPU retires the instruction at the end of the cycle.
  - req_valid is ignored (it still shows the same instruction).
  - Next state is always IDLE.
- Latency:
  - Minimum 3 cycles (accept, one BUSY with ack, DONE); each extra BUSY cycle adds one.
  - Misaligned access takes 2 cycles (accept, DONE) and never asserts mem_req.
- Alignment (o=addr[1:0]):
  - funct3 000/100 (byte): never misaligned.
  - funct3 001/101 (half): misaligned if o[0]=1.
  - All other funct3: misaligned if o!=0.
- Stores (funct3[1:0]):
  - 00: mem_be=0001<<o, mem_wdata={4{wdata[7:0]}}.
  - 01: mem_be=0011<<(2*o[1]), mem_wdata={2{wdata[15:0]}}.
  - Otherwise (sw and illegal): mem_be=1111, mem_wdata=wdata.
- Loads:
  - mem_we=0, mem_be=1111, mem_wdata=0.
  - s = mem_rdata >> (8*o).
  - 000: sign-extend s[7:0]. 001: sign-extend s[15:0]. 100: zero-extend s[7:0]. 101: zero-extend s[15:0].
  - All others: full word.
- Store completion: rsp_rdata=0.
- rsp_rdata holds its value until the next DONE; it is meaningful only with rsp_valid.

Test Plan:
- sw addr 0x100, wdata 0xDEADBEEF, ack on 2nd BUSY cycle -> mem_we=1, mem_addr=0x100, mem_be=1111, mem_wdata=0xDEADBEEF; stall high 3 cycles, rsp_valid 1 pulse, rsp_rdata=0.
- lb addr 0x103, mem_rdata 0x80FFFFFF, ack 1st BUSY -> mem_addr=0x100, rsp_rdata=0xFFFFFF80; lbu same -> 0x00000080; lh addr 0x102 -> 0xFFFF80FF; lhu -> 0x000080FF.
- sh addr 0x102, wdata 0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD; sb addr 0x101 wdata 0x55 -> mem_be=0010, mem_wdata=0x55555555.
- lw addr 0x102 -> mem_req never 1, stall 1 cycle, next cycle rsp_valid=1, misalign=1, rsp_rdata=0; sh addr 0x101 likewise.
- TIMEOUT=4, lw 0x200, mem_ack held 0 -> mem_req high exactly 4 cycles, then rsp_valid=1, bus_err=1, rsp_rdata=0, FSM back to IDLE.
- reset low during 2nd BUSY cycle, mem_ack=1 on the cycle after reset release -> all outputs 0 after the edge, no rsp_valid, and the next req_valid starts a fresh access.
